// File: rtl/gyro_cfg_pkg.sv
// Shared constants, types and the power-up default table for the gyro
// configuration sequencer.
package gyro_cfg_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int N_INIT = 22;
  localparam int N_CFG  = 25;
  localparam int N_ALL  = 50;
  localparam int IDX_W  = 5;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_IDLE = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_CAP  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cfg_entry_t;

  // Entries 3.. map one-to-one onto addresses 3.. with a ramp of data values.
  function automatic cfg_entry_t default_entry(input logic [IDX_W-1:0] idx);
    cfg_entry_t e;
    e.addr = '0;
    e.data = '0;
    case (idx)
      5'd0: begin e.addr = 6'd0; e.data = 32'h0000_0064; end
      5'd1: begin e.addr = 6'd2; e.data = 32'h0000_01F4; end
      5'd2: begin e.addr = 6'd1; e.data = 32'h0000_000A; end
      default: begin
        if ({1'b0, idx} < 6'(N_INIT)) begin
          e.addr = {1'b0, idx};
          e.data = 32'h0000_0100 + {27'd0, idx};
        end else begin
          e.addr = '0;
          e.data = '0;
        end
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/gyro_cfg_sequencer_default_rom.sv
// Combinational lookup of the default configuration table.
module gyro_cfg_sequencer_default_rom
  import gyro_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output cfg_entry_t       entry_o
);

  assign entry_o = default_entry(idx_i);

endmodule

// File: rtl/gyro_cfg_sequencer.sv
// Avalon-MM master for the gyro register bank: default-table burst after
// reset, then round-robin service of two requesters.
module gyro_cfg_sequencer
  import gyro_cfg_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reload_i,
  input  logic              r0_req_i,
  input  logic              r1_req_i,
  input  logic              r0_wr_i,
  input  logic              r1_wr_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r0_gnt_o,
  output logic              r1_gnt_o,
  output logic              r0_rvalid_o,
  output logic              r1_rvalid_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  output logic              r0_err_o,
  output logic              r1_err_o,
  output logic [ADDR_W-1:0] av_address_o,
  output logic              av_chipselect_o,
  output logic              av_write_n_o,
  output logic [DATA_W-1:0] av_writedata_o,
  input  logic [DATA_W-1:0] av_readdata_i,
  output logic              init_done_o,
  output logic              busy_o
);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    rr_q, rr_d;
  logic                    who_q, who_d;
  logic                    ill_q, ill_d;
  logic                    pend_q, pend_d;
  logic                    init_done_q, init_done_d;
  logic                    busy_q, busy_d;
  logic                    cs_q, cs_d;
  logic                    wn_q, wn_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              err_q, err_d;
  logic [1:0]              rvalid_q, rvalid_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;

  cfg_entry_t              rom_entry_s;
  logic                    win_s;
  logic                    sel_wr_s;
  logic [ADDR_W-1:0]       sel_addr_s;
  logic [DATA_W-1:0]       sel_wdata_s;
  logic                    ill_s;

  gyro_cfg_sequencer_default_rom u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry_s)
  );

  // Next-state, arbitration and bus/response output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    who_d       = who_q;
    ill_d       = ill_q;
    pend_d      = pend_q;
    init_done_d = init_done_q;
    cs_d        = 1'b0;
    wn_d        = wn_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gnt_d       = 2'b00;
    err_d       = 2'b00;
    rvalid_d    = 2'b00;
    rdata_d     = rdata_q;
    win_s       = (r0_req_i && r1_req_i) ? rr_q : r1_req_i;
    sel_wr_s    = win_s ? r1_wr_i    : r0_wr_i;
    sel_addr_s  = win_s ? r1_addr_i  : r0_addr_i;
    sel_wdata_s = win_s ? r1_wdata_i : r0_wdata_i;
    ill_s       = sel_wr_s ? (sel_addr_s >= ADDR_W'(N_CFG)) : (sel_addr_s >= ADDR_W'(N_ALL));

    case (state_q)
      ST_LOAD: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = rom_entry_s.addr;
        wdata_d = rom_entry_s.data;
        if (idx_q == IDX_W'(N_INIT - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          idx_d       = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      ST_IDLE: begin
        if (reload_i || pend_q) begin
          state_d     = ST_LOAD;
          idx_d       = '0;
          init_done_d = 1'b0;
          pend_d      = 1'b0;
        end else if (r0_req_i || r1_req_i) begin
          rr_d         = ~win_s;
          who_d        = win_s;
          ill_d        = ill_s;
          gnt_d[win_s] = 1'b1;
          err_d[win_s] = ill_s;
          state_d      = sel_wr_s ? ST_WR : ST_RD;
          // An illegal access is acknowledged but never reaches the bus.
          if (!ill_s) begin
            cs_d    = 1'b1;
            wn_d    = ~sel_wr_s;
            addr_d  = sel_addr_s;
            wdata_d = sel_wr_s ? sel_wdata_s : wdata_q;
          end else begin
            cs_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR:  state_d = ST_IDLE;
      ST_RD:  state_d = ST_CAP;
      ST_CAP: begin
        rdata_d[who_q]  = ill_q ? '0 : av_readdata_i;
        rvalid_d[who_q] = 1'b1;
        state_d         = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
    endcase

    if (reload_i && (state_q != ST_LOAD) && (state_q != ST_IDLE)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset restarts the default load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      rr_q        <= 1'b0;
      who_q       <= 1'b0;
      ill_q       <= 1'b0;
      pend_q      <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      cs_q        <= 1'b0;
      wn_q        <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_q       <= 2'b00;
      err_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      who_q       <= who_d;
      ill_q       <= ill_d;
      pend_q      <= pend_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      wn_q        <= wn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign r0_gnt_o        = gnt_q[0];
  assign r1_gnt_o        = gnt_q[1];
  assign r0_err_o        = err_q[0];
  assign r1_err_o        = err_q[1];
  assign r0_rvalid_o     = rvalid_q[0];
  assign r1_rvalid_o     = rvalid_q[1];
  assign r0_rdata_o      = rdata_q[0];
  assign r1_rdata_o      = rdata_q[1];
  assign av_address_o    = addr_q;
  assign av_chipselect_o = cs_q;
  assign av_write_n_o    = wn_q;
  assign av_writedata_o  = wdata_q;
  assign init_done_o     = init_done_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_gyro_cfg_sequencer.sv
// Self-checking bench: bank model, grant/response monitor and a transaction-level
// reference model of arbitration, legality and bank contents.
module tb_gyro_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reload = 1'b0;
  logic        r0_req = 1'b0, r1_req = 1'b0, r0_wr = 1'b0, r1_wr = 1'b0;
  logic [5:0]  r0_addr = 6'd0, r1_addr = 6'd0;
  logic [31:0] r0_wdata = 32'd0, r1_wdata = 32'd0;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [5:0]  av_addr;
  logic        av_cs, av_wn;
  logic [31:0] av_wd;
  logic [31:0] av_readdata = 32'd0;
  logic        init_done, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cs_cnt = 0;

  logic [31:0] bank [0:24];
  logic [31:0] mdl  [0:24];
  logic [5:0]  tbl_addr [0:21];
  logic [31:0] tbl_data [0:21];
  int          rr_m = 0;

  typedef struct { int who; logic err; logic cs; logic wn; logic [5:0] addr; logic [31:0] wd; int cyc; } gev_t;
  typedef struct { int who; logic [31:0] data; int cyc; } rev_t;
  gev_t gq[$];
  rev_t rq[$];

  gyro_cfg_sequencer dut (
    .clk_i(clk), .rst_i(rst), .reload_i(reload),
    .r0_req_i(r0_req), .r1_req_i(r1_req), .r0_wr_i(r0_wr), .r1_wr_i(r1_wr),
    .r0_addr_i(r0_addr), .r1_addr_i(r1_addr), .r0_wdata_i(r0_wdata), .r1_wdata_i(r1_wdata),
    .r0_gnt_o(r0_gnt), .r1_gnt_o(r1_gnt), .r0_rvalid_o(r0_rvalid), .r1_rvalid_o(r1_rvalid),
    .r0_rdata_o(r0_rdata), .r1_rdata_o(r1_rdata), .r0_err_o(r0_err), .r1_err_o(r1_err),
    .av_address_o(av_addr), .av_chipselect_o(av_cs), .av_write_n_o(av_wn),
    .av_writedata_o(av_wd), .av_readdata_i(av_readdata),
    .init_done_o(init_done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] status_val(input logic [5:0] a);
    if (a == 6'd30) return 32'h0000_1234;
    return {16'hC0DE, 10'd0, a};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (av_cs && !av_wn && av_addr < 6'd25) bank[av_addr] <= av_wd;
    if (av_cs && av_wn) av_readdata <= (av_addr < 6'd25) ? bank[av_addr] : status_val(av_addr);
  end

  always @(negedge clk) begin
    if (av_cs) cs_cnt <= cs_cnt + 1;
    if (r0_gnt) gq.push_back('{0, r0_err, av_cs, av_wn, av_addr, av_wd, cyc});
    if (r1_gnt) gq.push_back('{1, r1_err, av_cs, av_wn, av_addr, av_wd, cyc});
    if (r0_rvalid) rq.push_back('{0, r0_rdata, cyc});
    if (r1_rvalid) rq.push_back('{1, r1_rdata, cyc});
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 200);
    if (busy !== 1'b0) begin
      checks++; failures++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic run_txn(input logic q0, input logic q1, input logic w0, input logic [5:0] a0,
                         input logic [31:0] d0, input logic w1, input logic [5:0] a1, input logic [31:0] d1);
    int n = 0;
    wait_idle();
    r0_wr = w0; r0_addr = a0; r0_wdata = d0; r0_req = q0;
    r1_wr = w1; r1_addr = a1; r1_wdata = d1; r1_req = q1;
    while ((r0_req || r1_req) && n < 50) begin
      @(negedge clk);
      n++;
      if (r0_gnt) r0_req = 1'b0;
      if (r1_gnt) r1_req = 1'b0;
    end
    if (r0_req || r1_req) begin
      checks++; failures++;
      $display("FAIL grant_timeout: req0=%b req1=%b still pending, required granted", r0_req, r1_req);
      r0_req = 1'b0; r1_req = 1'b0;
    end
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; reload = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (av_cs !== 1'b0 || av_wn !== 1'b1 || av_addr !== 6'd0 || av_wd !== 32'd0 ||
        {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err} !== 6'd0 ||
        r0_rdata !== 32'd0 || r1_rdata !== 32'd0 || init_done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: cs=%b wn=%b addr=%0d init_done=%b busy=%b rdata0=%h, required 0 1 0 0 1 0",
               av_cs, av_wn, av_addr, init_done, busy, r0_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      checks++;
      if (av_cs !== 1'b1 || av_wn !== 1'b0 || av_addr !== tbl_addr[i] || av_wd !== tbl_data[i] ||
          (i < 21 && init_done !== 1'b0)) begin
        failures++;
        $display("FAIL load_strobe[%0d]: cs=%b wn=%b addr=%0d data=%h done=%b, required 1 0 %0d %h",
                 i, av_cs, av_wn, av_addr, av_wd, init_done, tbl_addr[i], tbl_data[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (av_cs !== 1'b0 || init_done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL load_end: cs=%b init_done=%b busy=%b, required 0 1 0", av_cs, init_done, busy);
    end
    for (int i = 0; i < 22; i++) mdl[tbl_addr[i]] = tbl_data[i];
    checks++;
    for (int i = 0; i < 25; i++) begin
      if (bank[i] !== mdl[i]) begin
        failures++;
        $display("FAIL load_bank[%0d]: got %h, required %h", i, bank[i], mdl[i]);
        break;
      end
    end
  endtask

  task automatic test_write();
    wait_idle();
    r0_wr = 1'b1; r0_addr = 6'd7; r0_wdata = 32'hA5A5_0001; r0_req = 1'b1;
    @(negedge clk);
    checks++;
    if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0 || r0_err !== 1'b0 || av_cs !== 1'b1 || av_wn !== 1'b0 ||
        av_addr !== 6'd7 || av_wd !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL write_strobe: gnt0=%b err0=%b cs=%b wn=%b addr=%0d data=%h, required 1 0 1 0 7 a5a50001",
               r0_gnt, r0_err, av_cs, av_wn, av_addr, av_wd);
    end
    r0_req = 1'b0;
    @(negedge clk);
    mdl[7] = 32'hA5A5_0001;
    rr_m = 1;
    checks++;
    if (busy !== 1'b0 || av_cs !== 1'b0 || bank[7] !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL write_done: busy=%b cs=%b reg7=%h, required 0 0 a5a50001", busy, av_cs, bank[7]);
    end
  endtask

  task automatic test_read();
    wait_idle();
    r1_wr = 1'b0; r1_addr = 6'd30; r1_req = 1'b1;
    @(negedge clk);
    checks++;
    if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0 || av_cs !== 1'b1 || av_wn !== 1'b1 || av_addr !== 6'd30) begin
      failures++;
      $display("FAIL read_strobe: gnt1=%b gnt0=%b cs=%b wn=%b addr=%0d, required 1 0 1 1 30",
               r1_gnt, r0_gnt, av_cs, av_wn, av_addr);
    end
    r1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (av_cs !== 1'b0 || r1_rvalid !== 1'b0 || r0_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL read_cap: cs=%b rv1=%b rv0=%b, required 0 0 0", av_cs, r1_rvalid, r0_rvalid);
    end
    @(negedge clk);
    checks++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== 32'h0000_1234 || r0_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL read_resp: rv1=%b rdata1=%h rv0=%b, required 1 00001234 0", r1_rvalid, r1_rdata, r0_rvalid);
    end
    @(negedge clk);
    checks++;
    if (r1_rvalid !== 1'b0 || r1_rdata !== 32'h0000_1234) begin
      failures++;
      $display("FAIL read_hold: rv1=%b rdata1=%h, required 0 00001234", r1_rvalid, r1_rdata);
    end
    rq.delete();
    run_txn(1'b1, 1'b0, 1'b0, 6'd2, 32'd0, 1'b0, 6'd0, 32'd0);
    rr_m = 1;
    checks++;
    if (rq.size() != 1 || rq[0].who != 0 || rq[0].data !== 32'h0000_01F4) begin
      failures++;
      $display("FAIL read_cfg2: responses=%0d data=%h, required 1 000001f4", rq.size(),
               (rq.size() > 0) ? rq[0].data : 32'hx);
    end
  endtask

  task automatic test_rr();
    test_reset();
    gq.delete();
    for (int k = 0; k < 4; k++) begin
      logic [5:0]  a0 = 6'($urandom_range(0, 24));
      logic [5:0]  a1 = 6'($urandom_range(0, 24));
      logic [31:0] d0 = $urandom;
      logic [31:0] d1 = $urandom;
      run_txn(1'b1, 1'b1, 1'b1, a0, d0, 1'b1, a1, d1);
      mdl[a0] = d0;
      mdl[a1] = d1;
    end
    checks++;
    if (gq.size() != 8) begin
      failures++;
      $display("FAIL rr_count: grants=%0d, required 8", gq.size());
    end
    for (int j = 0; j < gq.size() && j < 8; j++) begin
      checks++;
      if (gq[j].who != (j % 2)) begin
        failures++;
        $display("FAIL rr_order[%0d]: granted r%0d, required r%0d", j, gq[j].who, j % 2);
      end
    end
  endtask

  task automatic test_illegal();
    int c0;
    gq.delete(); rq.delete();
    c0 = cs_cnt;
    run_txn(1'b1, 1'b0, 1'b1, 6'd30, 32'hDEAD_BEEF, 1'b0, 6'd0, 32'd0);
    run_txn(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd55, 32'd0);
    checks++;
    if (gq.size() != 2 || gq[0].who != 0 || gq[0].err !== 1'b1 || gq[0].cs !== 1'b0 ||
        gq[1].who != 1 || gq[1].err !== 1'b1 || gq[1].cs !== 1'b0) begin
      failures++;
      $display("FAIL illegal_gnt: grants=%0d first=r%0d err=%b cs=%b, required 2 r0/r1 err=1 cs=0",
               gq.size(), (gq.size() > 0) ? gq[0].who : -1,
               (gq.size() > 0) ? gq[0].err : 1'bx, (gq.size() > 0) ? gq[0].cs : 1'bx);
    end
    checks++;
    if (cs_cnt != c0) begin
      failures++;
      $display("FAIL illegal_nostrobe: strobes=%0d, required 0", cs_cnt - c0);
    end
    checks++;
    if (rq.size() != 1 || rq[0].who != 1 || rq[0].data !== 32'd0 ||
        (gq.size() == 2 && rq[0].cyc != gq[1].cyc + 2)) begin
      failures++;
      $display("FAIL illegal_read_resp: responses=%0d data=%h, required 1 00000000 at gnt+2",
               rq.size(), (rq.size() > 0) ? rq[0].data : 32'hx);
    end
    rr_m = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int          pat = $urandom_range(1, 3);
      logic        q[2];
      logic        w[2];
      logic [5:0]  a[2];
      logic [31:0] d[2];
      int          order[$];
      logic [31:0] exp_rd[$];
      int          exp_rw[$];
      int          legal = 0;
      int          c0;
      for (int r = 0; r < 2; r++) begin
        q[r] = (pat >> r) & 1;
        w[r] = 1'($urandom_range(0, 1));
        a[r] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 49));
        d[r] = $urandom;
      end
      if (q[0] && q[1]) begin
        order.push_back(rr_m); order.push_back(1 - rr_m);
      end else begin
        order.push_back(q[1] ? 1 : 0);
        rr_m = q[1] ? 0 : 1;
      end
      gq.delete(); rq.delete();
      c0 = cs_cnt;
      run_txn(q[0], q[1], w[0], a[0], d[0], w[1], a[1], d[1]);
      for (int j = 0; j < order.size(); j++) begin
        int   r = order[j];
        logic ill = w[r] ? (a[r] >= 6'd25) : (a[r] >= 6'd50);
        checks++;
        if (j >= gq.size() || gq[j].who != r || gq[j].err !== ill || gq[j].cs !== !ill ||
            (!ill && (gq[j].wn !== !w[r] || gq[j].addr !== a[r] || (w[r] && gq[j].wd !== d[r])))) begin
          failures++;
          $display("FAIL rand_gnt[%0d.%0d]: got r%0d err=%b cs=%b addr=%0d, required r%0d err=%b cs=%b addr=%0d",
                   k, j, (j < gq.size()) ? gq[j].who : -1, (j < gq.size()) ? gq[j].err : 1'bx,
                   (j < gq.size()) ? gq[j].cs : 1'bx, (j < gq.size()) ? gq[j].addr : 6'bx, r, ill, !ill, a[r]);
        end
        if (!ill) legal++;
        if (w[r] && !ill) mdl[a[r]] = d[r];
        if (!w[r]) begin
          exp_rw.push_back(r);
          exp_rd.push_back(ill ? 32'd0 : (a[r] < 6'd25) ? mdl[a[r]] : status_val(a[r]));
        end
      end
      checks++;
      if (gq.size() != order.size() || cs_cnt - c0 != legal) begin
        failures++;
        $display("FAIL rand_count[%0d]: grants=%0d strobes=%0d, required %0d %0d",
                 k, gq.size(), cs_cnt - c0, order.size(), legal);
      end
      checks++;
      if (rq.size() != exp_rd.size()) begin
        failures++;
        $display("FAIL rand_rvalid_count[%0d]: got %0d, required %0d", k, rq.size(), exp_rd.size());
      end else begin
        for (int j = 0; j < rq.size(); j++) begin
          if (rq[j].who != exp_rw[j] || rq[j].data !== exp_rd[j]) begin
            failures++;
            $display("FAIL rand_rdata[%0d.%0d]: r%0d data=%h, required r%0d %h",
                     k, j, rq[j].who, rq[j].data, exp_rw[j], exp_rd[j]);
            break;
          end
        end
      end
    end
    checks++;
    for (int i = 0; i < 25; i++) begin
      if (bank[i] !== mdl[i]) begin
        failures++;
        $display("FAIL rand_bank[%0d]: got %h, required %h", i, bank[i], mdl[i]);
        break;
      end
    end
  endtask

  task automatic test_reload_rst();
    int t0;
    int n = 0;
    wait_idle();
    t0 = cyc;
    r0_wr = 1'b0; r0_addr = 6'd2; r0_req = 1'b1;
    @(negedge clk);
    checks++;
    if (r0_gnt !== 1'b1) begin
      failures++;
      $display("FAIL reload_gnt: gnt0=%b, required 1", r0_gnt);
    end
    r0_req = 1'b0; reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    @(negedge clk);
    checks++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== mdl[2] || init_done !== 1'b1) begin
      failures++;
      $display("FAIL reload_read_done: rv0=%b rdata0=%h done=%b, required 1 %h 1", r0_rvalid, r0_rdata, init_done, mdl[2]);
    end
    while (av_cs !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc != t0 + 6 || av_addr !== tbl_addr[0] || av_wd !== tbl_data[0] || init_done !== 1'b0) begin
      failures++;
      $display("FAIL reload_start: cycle=+%0d addr=%0d done=%b, required +6 %0d 0", cyc - t0, av_addr, init_done, tbl_addr[0]);
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (av_cs !== 1'b1 || av_addr !== tbl_addr[i] || av_wd !== tbl_data[i] || init_done !== 1'b0) begin
        failures++;
        $display("FAIL reload_strobe[%0d]: cs=%b addr=%0d data=%h, required 1 %0d %h", i, av_cs, av_addr, av_wd, tbl_addr[i], tbl_data[i]);
      end
    end
    test_reset();
  endtask

  initial begin
    for (int i = 0; i < 22; i++) begin
      tbl_addr[i] = 6'(i);
      tbl_data[i] = 32'h0000_0100 + i;
    end
    tbl_addr[0] = 6'd0; tbl_data[0] = 32'h0000_0064;
    tbl_addr[1] = 6'd2; tbl_data[1] = 32'h0000_01F4;
    tbl_addr[2] = 6'd1; tbl_data[2] = 32'h0000_000A;
    for (int i = 0; i < 25; i++) begin
      bank[i] = 32'd0;
      mdl[i]  = 32'd0;
    end
    test_reset();
    test_write();
    test_read();
    test_rr();
    test_illegal();
    test_random();
    test_reload_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
